// File: rtl/fetch_sequencer.sv
// ---------------------------------------------------------------------------
// fetch_sequencer
//
// Program-counter sequencer sitting between core-level control and the `top`
// datapath. It owns the `pc` register and issues one fetch address at a
// time. It then holds `pc` stable until the datapath reports that the issued
// instruction has finished (`exec_done`), and only then loads `newPC`. This
// closes the race where a free-running PC could advance before the previous
// instruction had executed.
//
// Parameters
//   PC_WIDTH      width of pc / newPC (at least 3)
//   RESET_PC      address used after reset and on every (re)start
//   EXEC_TIMEOUT  EXEC cycles allowed without exec_done before a fault (>= 1)
//
// Ports
//   clk          single clock, rising edge
//   rst          asynchronous, active-low reset
//   start        begin execution from RESET_PC (seen in IDLE / HALT only)
//   halt_req     stop after the current instruction retires
//   exec_done    datapath finished the issued instruction, newPC valid
//   newPC        next address computed by the datapath
//   pc           registered fetch address into the datapath
//   fetch_valid  one-cycle pulse: pc holds a new address to fetch
//   busy         high while issuing or executing
//   halted       high while stopped in HALT
//   fault        sticky error flag (timeout or misaligned target)
//   retired      saturating count of retired instructions
//
// Optional feature
//   FETCH_SEQ_ALIGN_CHECK_EN  when defined, a newPC with nonzero [1:0] on
//   exec_done raises fault and halts with pc and retired untouched. When
//   undefined, targets are silently word-aligned.
// ---------------------------------------------------------------------------
module fetch_sequencer #(
   parameter int                    PC_WIDTH     = 4,
   parameter logic [PC_WIDTH-1:0]   RESET_PC     = '0,
   parameter int                    EXEC_TIMEOUT = 15
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                start,
   input  logic                halt_req,
   input  logic                exec_done,
   input  logic [PC_WIDTH-1:0] newPC,
   output logic [PC_WIDTH-1:0] pc,
   output logic                fetch_valid,
   output logic                busy,
   output logic                halted,
   output logic                fault,
   output logic [7:0]          retired
);

   // The counter must be able to hold EXEC_TIMEOUT-1, which is the value it
   // has during the last permitted EXEC cycle.
   localparam int CNT_W = (EXEC_TIMEOUT > 1) ? $clog2(EXEC_TIMEOUT) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(EXEC_TIMEOUT - 1);

   // Clearing the two low address bits word-aligns a target address.
   localparam logic [PC_WIDTH-1:0] ALIGN_MASK = {{(PC_WIDTH-2){1'b1}}, 2'b00};

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      EXEC  = 2'd2,
      HALT  = 2'd3
   } state_t;

   state_t             state;
   state_t             state_next;
   logic [CNT_W-1:0]   exec_cnt;
   logic [PC_WIDTH-1:0] aligned_pc;
   logic               misalign;
   logic               in_exec;
   logic               accept;
   logic               bad_align;
   logic               timeout_hit;

   // Qualify the datapath handshake. exec_done only means something in EXEC.
   // A timeout is ignored if exec_done arrives in the same cycle, so the
   // instruction retires normally instead of faulting.
   always_comb begin
      aligned_pc = newPC & ALIGN_MASK;
`ifdef FETCH_SEQ_ALIGN_CHECK_EN
      misalign   = |newPC[1:0];
`else
      misalign   = 1'b0;
`endif
      in_exec     = (state == EXEC);
      accept      = in_exec && exec_done && !misalign;
      bad_align   = in_exec && exec_done && misalign;
      timeout_hit = in_exec && !exec_done && (exec_cnt == CNT_LAST);
   end

   // State register. Reset drops straight back to IDLE, which also aborts
   // any instruction that is still in flight.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state logic. start only matters in IDLE and HALT, and halt_req
   // only matters on the exec_done cycle. A misaligned target or a timeout
   // goes to HALT so that software has to restart explicitly.
   always_comb begin
      state_next = state;
      case (state)
         IDLE: begin
            if (start) begin
               state_next = ISSUE;
            end
         end
         ISSUE: begin
            state_next = EXEC;
         end
         EXEC: begin
            if (exec_done) begin
               if (misalign || halt_req) begin
                  state_next = HALT;
               end else begin
                  state_next = ISSUE;
               end
            end else if (timeout_hit) begin
               state_next = HALT;
            end
         end
         HALT: begin
            if (start) begin
               state_next = ISSUE;
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // Status outputs decode directly from the registered state, so they are
   // glitch-free and line up with the cycle the state is in.
   always_comb begin
      fetch_valid = (state == ISSUE);
      busy        = (state == ISSUE) || (state == EXEC);
      halted      = (state == HALT);
   end

   // Datapath registers: pc, retire counter, sticky fault and EXEC timeout
   // counter. pc changes only on an accepted exec_done or on a (re)start,
   // which is what keeps the fetch address stable while the datapath works.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pc       <= RESET_PC;
         retired  <= 8'd0;
         fault    <= 1'b0;
         exec_cnt <= '0;
      end else begin
         case (state)
            IDLE: begin
               pc       <= RESET_PC;
               exec_cnt <= '0;
            end
            ISSUE: begin
               exec_cnt <= '0;
            end
            EXEC: begin
               if (accept) begin
                  pc       <= aligned_pc;
                  exec_cnt <= '0;
                  if (retired != 8'hFF) begin
                     retired <= retired + 8'd1;
                  end
               end else if (bad_align) begin
                  fault    <= 1'b1;
                  exec_cnt <= '0;
               end else if (timeout_hit) begin
                  fault    <= 1'b1;
                  exec_cnt <= '0;
               end else begin
                  exec_cnt <= exec_cnt + 1'b1;
               end
            end
            HALT: begin
               exec_cnt <= '0;
               if (start) begin
                  pc      <= RESET_PC;
                  retired <= 8'd0;
                  fault   <= 1'b0;
               end
            end
            default: begin
               exec_cnt <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_fetch_sequencer.sv
// ---------------------------------------------------------------------------
// tb_fetch_sequencer
//
// Directed bench for fetch_sequencer with default parameters (4-bit pc,
// RESET_PC = 0, EXEC_TIMEOUT = 15). Each exec_done answered by the bench
// pushes the pc it expects to see on the next fetch_valid pulse. A monitor
// pops and compares on every pulse. State-level outputs are checked
// directly at the steps where they matter.
// ---------------------------------------------------------------------------
module tb_fetch_sequencer;

   logic       clk;
   logic       rst;
   logic       start;
   logic       halt_req;
   logic       exec_done;
   logic [3:0] newPC;
   logic [3:0] pc;
   logic       fetch_valid;
   logic       busy;
   logic       halted;
   logic       fault;
   logic [7:0] retired;

   int         compared;
   int         mismatched;
   int         fvCount;
   int         fvSnap;
   logic [3:0] expQ[$];

   fetch_sequencer #(
      .PC_WIDTH    (4),
      .RESET_PC    (4'b0000),
      .EXEC_TIMEOUT(15)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .halt_req   (halt_req),
      .exec_done  (exec_done),
      .newPC      (newPC),
      .pc         (pc),
      .fetch_valid(fetch_valid),
      .busy       (busy),
      .halted     (halted),
      .fault      (fault),
      .retired    (retired)
   );

   // Free-running clock, 10 time units per period.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // One comparison: count it, and on a miss count and report it.
   task automatic checkOutput(input string tag, input logic [31:0] obs,
                              input logic [31:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Step to the next falling edge. Inputs are driven and outputs sampled
   // there, away from the rising edge the DUT acts on.
   task automatic applyStimulus;
      @(negedge clk);
   endtask

   // On each fetch pulse, compare pc with the oldest queued expectation.
   always @(negedge clk) begin
      if (rst && fetch_valid) begin
         fvCount++;
         if (expQ.size() == 0) begin
            checkOutput("unexpected_fetch", 32'd1, 32'd0);
         end else begin
            checkOutput("fetch_pc", {28'd0, pc}, {28'd0, expQ.pop_front()});
         end
      end
   end

   // Hard stop in case the sequence ever stalls.
   initial begin
      #50000;
      $display("[TB] FAIL watchdog: observed timeout expected finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      compared   = 0;
      mismatched = 0;
      fvCount    = 0;
      fvSnap     = 0;
      rst        = 1'b0;
      start      = 1'b0;
      halt_req   = 1'b0;
      exec_done  = 1'b0;
      newPC      = 4'b0000;

      // Reset and idle behaviour.
      repeat (3) applyStimulus;
      checkOutput("rst_pc",      {28'd0, pc}, 32'd0);
      checkOutput("rst_busy",    {31'd0, busy}, 32'd0);
      checkOutput("rst_fault",   {31'd0, fault}, 32'd0);
      checkOutput("rst_retired", {24'd0, retired}, 32'd0);
      checkOutput("rst_halted",  {31'd0, halted}, 32'd0);
      rst       = 1'b1;
      exec_done = 1'b1;
      newPC     = 4'b1000;
      repeat (2) applyStimulus;
      exec_done = 1'b0;
      applyStimulus;
      checkOutput("idle_pc",      {28'd0, pc}, 32'd0);
      checkOutput("idle_retired", {24'd0, retired}, 32'd0);
      checkOutput("idle_busy",    {31'd0, busy}, 32'd0);

      // Jump then sequential: 0000 -> 1000 -> 1100.
      start = 1'b1;
      expQ.push_back(4'b0000);
      applyStimulus;
      start = 1'b0;
      checkOutput("issue_fv",   {31'd0, fetch_valid}, 32'd1);
      checkOutput("issue_busy", {31'd0, busy}, 32'd1);
      applyStimulus;
      exec_done = 1'b1;
      newPC     = 4'b1000;
      expQ.push_back(4'b1000);
      applyStimulus;
      exec_done = 1'b0;
      checkOutput("seq_retired1", {24'd0, retired}, 32'd1);
      applyStimulus;
      exec_done = 1'b1;
      newPC     = 4'b1100;
      expQ.push_back(4'b1100);
      applyStimulus;
      exec_done = 1'b0;
      checkOutput("seq_retired2", {24'd0, retired}, 32'd2);
      applyStimulus;

      // Back to 1000, then hold it for 5 EXEC cycles before completing.
      exec_done = 1'b1;
      newPC     = 4'b1000;
      expQ.push_back(4'b1000);
      applyStimulus;
      exec_done = 1'b0;
      applyStimulus;
      fvSnap = fvCount;
      for (int i = 0; i < 5; i++) begin
         checkOutput("hold_pc", {28'd0, pc}, 32'h8);
         checkOutput("hold_fv", {31'd0, fetch_valid}, 32'd0);
         applyStimulus;
      end
      checkOutput("hold_pulses", fvCount - fvSnap, 32'd0);
      exec_done = 1'b1;
      newPC     = 4'b1100;
      expQ.push_back(4'b1100);
      applyStimulus;
      exec_done = 1'b0;
      checkOutput("hold_retired", {24'd0, retired}, 32'd4);
      applyStimulus;

      // Timeout: 15 EXEC cycles with no exec_done, no fault before the last.
      for (int i = 1; i <= 15; i++) begin
         checkOutput("to_fault_early", {31'd0, fault}, 32'd0);
         checkOutput("to_busy", {31'd0, busy}, 32'd1);
         applyStimulus;
      end
      checkOutput("to_fault",   {31'd0, fault}, 32'd1);
      checkOutput("to_halted",  {31'd0, halted}, 32'd1);
      checkOutput("to_pc",      {28'd0, pc}, 32'hC);
      checkOutput("to_retired", {24'd0, retired}, 32'd4);
      applyStimulus;
      checkOutput("halt_held", {31'd0, halted}, 32'd1);

      // Restart from HALT clears fault and retired, and refetches 0000.
      start = 1'b1;
      expQ.push_back(4'b0000);
      applyStimulus;
      start = 1'b0;
      checkOutput("restart_fault",   {31'd0, fault}, 32'd0);
      checkOutput("restart_retired", {24'd0, retired}, 32'd0);
      applyStimulus;

      // halt_req with exec_done halts at the new pc.
      halt_req  = 1'b1;
      exec_done = 1'b1;
      newPC     = 4'b0100;
      applyStimulus;
      halt_req  = 1'b0;
      exec_done = 1'b0;
      checkOutput("halt_state",   {31'd0, halted}, 32'd1);
      checkOutput("halt_pc",      {28'd0, pc}, 32'h4);
      checkOutput("halt_retired", {24'd0, retired}, 32'd1);
      checkOutput("halt_fv",      {31'd0, fetch_valid}, 32'd0);

      // Misaligned target 0110.
      start = 1'b1;
      expQ.push_back(4'b0000);
      applyStimulus;
      start = 1'b0;
      applyStimulus;
      exec_done = 1'b1;
      newPC     = 4'b0110;
`ifdef FETCH_SEQ_ALIGN_CHECK_EN
      applyStimulus;
      exec_done = 1'b0;
      checkOutput("mis_fault",   {31'd0, fault}, 32'd1);
      checkOutput("mis_halted",  {31'd0, halted}, 32'd1);
      checkOutput("mis_pc",      {28'd0, pc}, 32'h0);
      checkOutput("mis_retired", {24'd0, retired}, 32'd0);
      start = 1'b1;
      expQ.push_back(4'b0000);
      applyStimulus;
      start = 1'b0;
      checkOutput("mis_pc_restart", {28'd0, pc}, 32'h0);
`else
      expQ.push_back(4'b0100);
      applyStimulus;
      exec_done = 1'b0;
      checkOutput("mis_pc",      {28'd0, pc}, 32'h4);
      checkOutput("mis_fault",   {31'd0, fault}, 32'd0);
      checkOutput("mis_retired", {24'd0, retired}, 32'd1);
`endif
      applyStimulus;

      // exec_done in the 15th EXEC cycle beats the timeout. halt_req held
      // while exec_done is low must not stop the sequencer.
      halt_req = 1'b1;
      for (int i = 1; i < 15; i++) begin
         applyStimulus;
      end
      checkOutput("late_halted", {31'd0, halted}, 32'd0);
      halt_req  = 1'b0;
      exec_done = 1'b1;
      newPC     = 4'b1000;
      expQ.push_back(4'b1000);
      applyStimulus;
      exec_done = 1'b0;
      checkOutput("late_fault", {31'd0, fault}, 32'd0);
      checkOutput("late_pc",    {28'd0, pc}, 32'h8);
      applyStimulus;

      // start during EXEC is ignored.
      start = 1'b1;
      applyStimulus;
      start = 1'b0;
      checkOutput("exec_start_fv", {31'd0, fetch_valid}, 32'd0);
      checkOutput("exec_start_pc", {28'd0, pc}, 32'h8);

      // Asynchronous reset mid-EXEC, with exec_done pending.
      exec_done = 1'b1;
      newPC     = 4'b1100;
      #2;
      rst = 1'b0;
      #1;
      checkOutput("mid_rst_pc",      {28'd0, pc}, 32'd0);
      checkOutput("mid_rst_busy",    {31'd0, busy}, 32'd0);
      checkOutput("mid_rst_fv",      {31'd0, fetch_valid}, 32'd0);
      checkOutput("mid_rst_halted",  {31'd0, halted}, 32'd0);
      checkOutput("mid_rst_fault",   {31'd0, fault}, 32'd0);
      checkOutput("mid_rst_retired", {24'd0, retired}, 32'd0);
      applyStimulus;
      exec_done = 1'b0;
      rst       = 1'b1;
      applyStimulus;
      checkOutput("post_rst_retired", {24'd0, retired}, 32'd0);
      checkOutput("post_rst_busy",    {31'd0, busy}, 32'd0);
      checkOutput("queue_drained",    expQ.size(), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/fetch_sequencer.md
# fetch_sequencer

Program-counter sequencer that owns the `pc` register and consumes the `newPC` result returned by the datapath (`top`). It issues one instruction address at a time and holds `pc` stable until the datapath signals that the current instruction has finished. Only then does it load `newPC`. This removes the race in which the PC advances before the previous instruction has executed. It sits between the core-level control and the `top` datapath, replacing the free-running PC feedback loop.

## Interface
- `PC_WIDTH`, 4, width of `pc` and `newPC`.
- `RESET_PC`, 0, address loaded on reset and on every (re)start.
- `EXEC_TIMEOUT`, 15, maximum number of EXEC cycles without `exec_done` before a fault is raised; must be ≥1.

Ports:
- `clk`  in  1  single clock; all state changes on the rising edge.
- `rst`  in  1  reset; asynchronous, active-low.
- `start`  in  1  begin execution from `RESET_PC`; level, sampled in IDLE or HALT only.
- `halt_req`  in  1  stop after the current instruction retires; sampled on the `exec_done` cycle.
- `exec_done`  in  1  datapath has finished the issued instruction and `newPC` is valid; honoured in EXEC only.
- `newPC`  in  PC_WIDTH  next-address result from the datapath.
- `pc`  out  PC_WIDTH  registered fetch address into `top`.
- `fetch_valid`  out  1  one-cycle pulse: `pc` is a new address to fetch.
- `busy`  out  1  high in ISSUE and EXEC.
- `halted`  out  1  high in HALT.
- `fault`  out  1  sticky error flag (timeout or misalignment).
- `retired`  out  8  count of retired instructions; saturates at 255.

## Operation
- States: IDLE, ISSUE, EXEC, HALT. Registered FSM; all outputs are registered or decoded from state.
- IDLE:
  - `pc`=`RESET_PC`.
  - `start`=1 → ISSUE.
- ISSUE:
  - `fetch_valid`=1 for exactly this cycle.
  - Always → EXEC next cycle.
  - `exec_done` is ignored here.
- EXEC:
  - `pc` is held and the timeout counter increments each cycle.
  - On `exec_done`:
    - `pc`←`newPC`.
    - `retired`+1, saturating.
    - Timeout counter cleared.
    - If `halt_req` → HALT, else → ISSUE.
  - Counter reaches `EXEC_TIMEOUT` with no `exec_done` → `fault`=1, HALT, `pc` unchanged.
  - `exec_done` and timeout in the same cycle: `exec_done` wins and no fault is raised.
- HALT:
  - `start`=1 → `pc`=`RESET_PC`, `retired`=0, `fault`=0, then ISSUE.
  - Otherwise HALT is held.
- `pc` wrap: `newPC` is loaded verbatim. The sequencer performs no PC arithmetic, so wrap-around is the datapath's responsibility.
- `halt_req` outside the `exec_done` cycle has no effect.
- `start` in ISSUE or EXEC is ignored.

## Timing
- Reset (`rst`=0, asynchronous) forces: state IDLE, `pc`=`RESET_PC`, `fetch_valid`=0, `busy`=0, `halted`=0, `fault`=0, `retired`=0, timeout counter=0.
- Reset asserted mid-EXEC aborts the instruction; its `exec_done` is not counted.
- `start` sampled at edge N → `fetch_valid`=1 during cycle N+1.
- `exec_done` sampled at edge M → new `pc` visible after edge M, with `fetch_valid`=1 in cycle M+1.
- Minimum throughput: 2 cycles per instruction (ISSUE + one EXEC cycle with `exec_done`).
- Timeout fires at the edge ending the `EXEC_TIMEOUT`th EXEC cycle.

## Configuration
- `FETCH_SEQ_ALIGN_CHECK_EN` defined:
  - On `exec_done`, a nonzero `newPC[1:0]` raises `fault`=1, moves to HALT, and leaves `pc` and `retired` unchanged.
- Not defined:
  - `pc`←{`newPC[PC_WIDTH-1:2]`,2'b00} and no fault is raised.
  - Misaligned targets are silently word-aligned.

## Test plan
- Reset/idle:
  - Hold `rst`=0, then release.
  - Expect `pc`=0000, `busy`=0, `fault`=0, `retired`=0.
  - `exec_done` pulses while in IDLE produce no change.
- Jump then sequential:
  - `start`, then answer `exec_done` with `newPC`=1000, then 1100.
  - Expect `pc` sequence 0000→1000→1100.
  - Expect `fetch_valid` one cycle after each update and `retired`=2.
- Hold until done:
  - Delay `exec_done` 5 cycles after ISSUE.
  - Expect `pc` stable at 1000 throughout and exactly one `fetch_valid` pulse.
- Timeout:
  - Never assert `exec_done`.
  - Expect `fault`=1 and `halted`=1 after 15 EXEC cycles, with `pc` unchanged.
  - `start` then clears `fault` and reissues `pc`=0000.
- Halt and misalignment:
  - `halt_req`=1 with `exec_done`, `newPC`=0100 → HALT, `pc`=0100.
  - `newPC`=0110 with the macro defined → fault, `pc` held.
  - `newPC`=0110 without the macro → `pc`=0100.
- Reset mid-EXEC:
  - Assert `rst`=0 asynchronously during EXEC.
  - Expect all outputs at their reset values immediately, with `retired`=0.
